// File: rtl/tick_generator_pkg.sv
// Shared mode encodings and width helper for the tick generator channels.
package tick_generator_pkg;

  localparam logic MODE_STROBE = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;

  // Channel index width, never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_generator_channel.sv
// One divider channel: counter, active/pending configuration and registered outputs.
module tick_generator_channel
  import tick_generator_pkg::*;
#(
  parameter int   CNT_W    = 21,
  parameter int   DEF_DIV  = 2,
  parameter logic DEF_MODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             wr_mode,
  output logic             tick_out,
  output logic             tc,
  output logic             busy
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act_div;
  logic [CNT_W-1:0] pend_div;
  logic             act_mode;
  logic             pend_mode;
  logic             terminal;
  logic             apply;
  logic             mode_chg;
  logic             hold_level;

  assign terminal = en && (act_div != '0) && (cnt == act_div - 1'b1);
  // Pending config lands only where it cannot cut a period short.
  assign apply    = busy && (terminal || !en);
  assign mode_chg = apply && (pend_mode != act_mode);
  // Level kept on non-terminal edges: square holds, strobe returns low.
  assign hold_level = (act_mode == MODE_SQUARE) && !mode_chg && tick_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      act_div   <= CNT_W'(DEF_DIV);
      pend_div  <= CNT_W'(DEF_DIV);
      act_mode  <= DEF_MODE;
      pend_mode <= DEF_MODE;
      tick_out  <= 1'b0;
      tc        <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (sync_clr) begin
        cnt      <= '0;
        tc       <= 1'b0;
        tick_out <= 1'b0;
        if (busy) begin
          act_div  <= pend_div;
          act_mode <= pend_mode;
        end
        busy <= 1'b0;
      end else begin
        if (apply) begin
          act_div  <= pend_div;
          act_mode <= pend_mode;
          busy     <= 1'b0;
        end
        if (act_div == '0) begin
          cnt      <= '0;
          tc       <= 1'b0;
          tick_out <= 1'b0;
        end else if (terminal) begin
          cnt <= '0;
          tc  <= 1'b1;
          if (mode_chg)
            tick_out <= 1'b0;
          else if (act_mode == MODE_SQUARE)
            tick_out <= ~tick_out;
          else
            tick_out <= 1'b1;
        end else if (en) begin
          cnt      <= cnt + 1'b1;
          tc       <= 1'b0;
          tick_out <= hold_level;
        end else begin
          cnt      <= apply ? '0 : cnt;
          tc       <= 1'b0;
          tick_out <= hold_level;
        end
      end
      // A write on an apply edge stays pending for the next opportunity.
      if (wr) begin
        pend_div  <= wr_div;
        pend_mode <= wr_mode;
        busy      <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_generator.sv
// Multi-channel tick/clock divider; the top only decodes configuration writes.
module tick_generator
  import tick_generator_pkg::*;
#(
  parameter int   NUM_CH   = 4,
  parameter int   CNT_W    = 21,
  parameter int   DEF_DIV  = 2,
  parameter logic DEF_MODE = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             ch_en,
  input  logic                          sync_clr,
  input  logic                          wr_en,
  input  logic [ch_idx_w(NUM_CH)-1:0]   wr_ch,
  input  logic [CNT_W-1:0]              wr_div,
  input  logic                          wr_mode,
  output logic [NUM_CH-1:0]             tick_out,
  output logic [NUM_CH-1:0]             tc,
  output logic [NUM_CH-1:0]             busy
);

  localparam int IDX_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] wr_sel;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Indices at or above NUM_CH match no channel and are dropped.
    assign wr_sel[i] = wr_en && (wr_ch == IDX_W'(i));

    tick_generator_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV),
      .DEF_MODE(DEF_MODE)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (ch_en[i]),
      .sync_clr(sync_clr),
      .wr      (wr_sel[i]),
      .wr_div  (wr_div),
      .wr_mode (wr_mode),
      .tick_out(tick_out[i]),
      .tc      (tc[i]),
      .busy    (busy[i])
    );
  end

endmodule

// File: tb/tb_tick_generator.sv
// Self-checking bench for tick_generator: vector table plus scripted multi-cycle sequences.
module tb_tick_generator;

  localparam int NCH = 3;

  logic           clk;
  logic           rst_n;
  logic [NCH-1:0] ch_en;
  logic           sync_clr;
  logic           wr_en;
  logic [1:0]     wr_ch;
  logic [7:0]     wr_div;
  logic           wr_mode;
  logic [NCH-1:0] tick_out;
  logic [NCH-1:0] tc;
  logic [NCH-1:0] busy;

  tick_generator #(
    .NUM_CH  (NCH),
    .CNT_W   (8),
    .DEF_DIV (2),
    .DEF_MODE(1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ch_en   (ch_en),
    .sync_clr(sync_clr),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
    .wr_mode (wr_mode),
    .tick_out(tick_out),
    .tc      (tc),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] en;
    logic       clr;
    logic       wr;
    logic [1:0] wch;
    logic [7:0] wdiv;
    logic       wmode;
    logic [2:0] tick;
    logic [2:0] tc;
    logic [2:0] busy;
    logic [2:0] mask;
  } vec_t;

  typedef struct {
    logic [2:0] tick;
    logic [2:0] tc;
    logic [2:0] busy;
    logic [2:0] mask;
    string      name;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[14];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic [2:0] en, input logic clr, input logic wr,
                              input logic [1:0] wch, input logic [7:0] wdiv, input logic wmode,
                              input logic [2:0] tk, input logic [2:0] t, input logic [2:0] b,
                              input logic [2:0] m);
    vec_t v;
    v.en = en; v.clr = clr; v.wr = wr; v.wch = wch; v.wdiv = wdiv; v.wmode = wmode;
    v.tick = tk; v.tc = t; v.busy = b; v.mask = m;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [2:0] got, input logic [2:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    ch_en = v.en; sync_clr = v.clr; wr_en = v.wr; wr_ch = v.wch;
    wr_div = v.wdiv; wr_mode = v.wmode;
  endtask

  // Drive one cycle without checking (used to set up a phase offset).
  task automatic step(input logic [2:0] en);
    drive(mk(en, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b0, 3'b0, 3'b0, 3'b0));
    @(posedge clk); #1;
  endtask

  task automatic apply_vec(input vec_t v, input string name);
    exp_t e;
    exp_t got;
    drive(v);
    e.tick = v.tick; e.tc = v.tc; e.busy = v.busy; e.mask = v.mask; e.name = name;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      got = sb.pop_front();
      cmp({got.name, " tick_out"}, tick_out & got.mask, got.tick & got.mask);
      cmp({got.name, " tc"},       tc & got.mask,       got.tc & got.mask);
      cmp({got.name, " busy"},     busy & got.mask,     got.busy & got.mask);
    end
  endtask

  // Periodic expectations: k counts enabled edges since the counter was last at zero.
  task automatic run_div(input logic [2:0] en, input logic [2:0] mask, input int d,
                         input logic square, input int k0, input int n, input string name);
    for (int k = k0; k < k0 + n; k++) begin
      logic tcb, tkb;
      tcb = (k % d) == 0;
      tkb = square ? (((k / d) % 2) == 1) : tcb;
      apply_vec(mk(en, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, {3{tkb}}, {3{tcb}}, 3'b0, mask),
                $sformatf("%s k=%0d", name, k));
    end
  endtask

  task automatic cfg(input int ch, input logic [7:0] div, input logic mode);
    logic [2:0] m;
    m = 3'(1 << ch);
    apply_vec(mk(3'b000, 1'b0, 1'b1, 2'(ch), div, mode, 3'b0, 3'b0, m, m), "cfg write");
    apply_vec(mk(3'b000, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b0, 3'b0, 3'b0, m), "cfg apply");
  endtask

  task automatic do_reset();
    drive(mk(3'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b0, 3'b0, 3'b0, 3'b0));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Out-of-range write, write then write-on-apply-edge, then ch1 strobe div 5.
    tbl[0] = mk(3'b000, 0, 1, 2'd3, 8'd5, 1'b0, 3'b000, 3'b000, 3'b000, 3'b111);
    tbl[1] = mk(3'b000, 0, 1, 2'd1, 8'd9, 1'b1, 3'b000, 3'b000, 3'b010, 3'b111);
    tbl[2] = mk(3'b000, 0, 1, 2'd1, 8'd5, 1'b0, 3'b000, 3'b000, 3'b010, 3'b111);
    tbl[3] = mk(3'b000, 0, 0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b111);
    for (int i = 4; i < 14; i++) begin
      logic hit;
      hit = ((i - 3) % 5) == 0;
      tbl[i] = mk(3'b010, 0, 0, 2'd0, 8'd0, 1'b0, {1'b0, hit, 1'b0}, {1'b0, hit, 1'b0},
                  3'b000, 3'b111);
    end

    rst_n = 1'b1;
    drive(mk(3'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b0, 3'b0, 3'b0, 3'b0));
    #2 rst_n = 1'b0;
    #2;
    cmp("reset tick_out", tick_out, 3'b000);
    cmp("reset tc", tc, 3'b000);
    cmp("reset busy", busy, 3'b000);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Default div 2 square on ch0.
    run_div(3'b001, 3'b001, 2, 1'b1, 1, 12, "t1 default sq");

    do_reset();
    for (int i = 0; i < 14; i++)
      apply_vec(tbl[i], $sformatf("t2 row%0d", i));

    // Two writes mid-count: last one (div 3) applies at the old terminal edge.
    do_reset();
    cfg(0, 8'd8, 1'b1);
    apply_vec(mk(3'b001, 0, 1, 2'd0, 8'd9, 1'b1, 3'b000, 3'b000, 3'b001, 3'b001), "t3 wr9");
    apply_vec(mk(3'b001, 0, 1, 2'd0, 8'd3, 1'b1, 3'b000, 3'b000, 3'b001, 3'b001), "t3 wr3");
    for (int k = 3; k < 8; k++)
      apply_vec(mk(3'b001, 0, 0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b001, 3'b001),
                $sformatf("t3 pend k=%0d", k));
    apply_vec(mk(3'b001, 0, 0, 2'd0, 8'd0, 1'b0, 3'b001, 3'b001, 3'b000, 3'b001), "t3 apply");
    for (int j = 1; j < 10; j++) begin
      logic tcb, tkb;
      tcb = (j % 3) == 0;
      tkb = ~(((j / 3) % 2) == 1);
      apply_vec(mk(3'b001, 0, 0, 2'd0, 8'd0, 1'b0, {2'b0, tkb}, {2'b0, tcb}, 3'b000, 3'b001),
                $sformatf("t3 div3 j=%0d", j));
    end

    // Divisor 0 stalls; divisor 1 in both modes.
    do_reset();
    cfg(0, 8'd0, 1'b0);
    for (int k = 0; k < 8; k++)
      apply_vec(mk(3'b001, 0, 0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b001), "t4 div0");
    cfg(0, 8'd1, 1'b0);
    run_div(3'b001, 3'b001, 1, 1'b0, 1, 6, "t4 div1 strobe");
    cfg(0, 8'd1, 1'b1);
    run_div(3'b001, 3'b001, 1, 1'b1, 1, 6, "t4 div1 sq");

    // Phase-offset channels realigned by sync_clr.
    do_reset();
    cfg(0, 8'd4, 1'b1);
    cfg(1, 8'd4, 1'b1);
    step(3'b001);
    step(3'b001);
    step(3'b011);
    step(3'b011);
    step(3'b011);
    apply_vec(mk(3'b011, 1, 0, 2'd0, 8'd0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b011), "t5 clr");
    run_div(3'b011, 3'b011, 4, 1'b1, 1, 8, "t5 aligned");

    // Async reset with a pending write restores defaults.
    do_reset();
    run_div(3'b001, 3'b001, 2, 1'b1, 1, 3, "t6 pre");
    apply_vec(mk(3'b001, 0, 1, 2'd0, 8'd5, 1'b1, 3'b000, 3'b001, 3'b001, 3'b001), "t6 wr");
    drive(mk(3'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'b0, 3'b0, 3'b0, 3'b0));
    #2 rst_n = 1'b0;
    #1;
    cmp("t6 async tick_out", tick_out, 3'b000);
    cmp("t6 async tc", tc, 3'b000);
    cmp("t6 async busy", busy, 3'b000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_div(3'b001, 3'b001, 2, 1'b1, 1, 4, "t6 defdiv");

    // ch_en dropped for 10 cycles: square level and count held.
    do_reset();
    cfg(0, 8'd4, 1'b1);
    run_div(3'b001, 3'b001, 4, 1'b1, 1, 5, "t7 run");
    for (int k = 0; k < 10; k++)
      apply_vec(mk(3'b000, 0, 0, 2'd0, 8'd0, 1'b0, 3'b001, 3'b000, 3'b000, 3'b001), "t7 frozen");
    run_div(3'b001, 3'b001, 4, 1'b1, 6, 6, "t7 resume");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
